instr_fetch_ctrl: RTL
=====================

// Module: instr_fetch_ctrl
// PURPOSE
//  Sequences the byte-addressed instruction ROM (async read, 4 bytes per word, big-endian concat).
//  Owns the PC and drives the ROM address.
//  Registers each fetched word into a valid/ready output stage for decode.
//  Handles branch redirects and flags misaligned or out-of-range fetches.
//  Sits between the ROM and the decode/regfile stage of the reduced RISC-V core.
// PARAMETERS
//  ADDRESS_WIDTH  32  PC / ROM address width (bits)
//  ROM_BYTES      28  ROM size in bytes; the last legal word starts at ROM_BYTES-4
//  RESET_PC       0   PC value loaded on reset
// PORTS
//  clk              in   1    clock; all state changes on rising edge
//  rst_n            in   1    reset, asynchronous, active-low
//  rom_addr         out  AW   byte address to ROM (combinational = pc_q)
//  rom_instr        in   32   ROM read data for rom_addr (combinational)
//  redirect_valid   in   1    branch/jump taken this cycle
//  redirect_target  in   AW   new PC when redirect_valid
//  out_ready        in   1    decode accepts instr this cycle
//  out_valid        out  1    instr_out/instr_pc hold a valid word
//  instr_out        out  32   fetched instruction
//  instr_pc         out  AW   byte address of instr_out
//  fault            out  1    sticky: misaligned or out-of-range fetch
//  fetch_count      out  32   number of words handed to decode (wraps at 2^32)
// BEHAVIOUR
//  - Reset (async assert, sync release): pc_q=RESET_PC, out_valid=0, instr_out=0,
//    instr_pc=0, fault=0, fetch_count=0, state=BOOT.
//  - States: BOOT -> FETCH unconditionally after one cycle (ROM settle); FETCH; FAULT.
//  - Handshake: a transfer occurs when out_valid && out_ready. fetch_count += 1 per transfer.
//    instr_out and instr_pc are stable while out_valid && !out_ready.
//  - Load condition in FETCH: slot_free = !out_valid || out_ready.
//  - On slot_free with a legal pc_q: instr_out<=rom_instr, instr_pc<=pc_q, out_valid<=1,
//    pc_q<=pc_q+4 (modulo 2^AW).
//    Latency: ROM address to out_valid is 1 cycle; 1 word/cycle sustained with out_ready=1.
//  - Legal pc: pc[1:0]==0 and pc <= ROM_BYTES-4. Compare in AW+1 bits so no wrap aliasing.
//  - Illegal pc with slot_free: no load, state<=FAULT, fault<=1, pc_q holds.
//    out_valid<=0 if the held word transfers; otherwise it keeps holding.
//  - FAULT: no fetches; the held word may still drain. Exit only by redirect to a legal target.
//  - Redirect (priority over everything except reset):
//    - Same edge: out_valid<=0 (held word flushed; a simultaneous transfer still counts).
//    - pc_q<=redirect_target, fault<=0.
//    - state<=FETCH if target legal, else state<=FAULT and fault<=1.
//    - The first post-redirect word appears 1 cycle later.
//    - Redirect during BOOT: accepted, and state moves to FETCH/FAULT as above.
//  - Wrap: pc_q+4 past ROM end becomes illegal and enters FAULT; it never wraps to 0.
//  - Reset mid-transfer: all outputs return to reset values immediately (async); no partial state.
// STRUCTURE
//  - Package fetch_pkg: typedef enum logic [1:0] {BOOT, FETCH, FAULT} fetch_state_t;
//    localparam INSTR_BYTES=4.
//  - One sub-module, fetch_out_reg: the valid/ready holding register (instr, pc, valid,
//    load, flush). PC/state/counter logic stays in the top.
//  - Combinational legality check as a function in fetch_pkg.
// TESTING
//  1. Reset, ROM words W0..W6, out_ready=1 -> BOOT 1 cycle.
//     Then instr_pc = 0,4,...,24 on consecutive cycles with W0..W6; fetch_count=7.
//  2. After pc=24 consumed -> pc_q=28 illegal: fault=1, out_valid=0, state FAULT, fetch_count stays 7.
//  3. out_ready=0 for 3 cycles with a word at pc=8 held -> instr_out/instr_pc stable, pc_q=12 held;
//     out_ready=1 -> pc=8 then pc=12 issue back-to-back.
//  4. Redirect to 0x10 while word at pc=4 held and out_ready=0 -> next cycle out_valid=0;
//     following cycle instr_pc=0x10, fetch_count unchanged.
//  5. Redirect to 0x06 (misaligned) -> fault=1, FAULT.
//     Then redirect to 0x00 -> fault=0, instr_pc=0 one cycle later.
//  6. rst_n low mid-stream (asynchronous, between edges) -> out_valid, fault, fetch_count
//     go to 0 without a clock edge; pc_q=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

    // A PC is fetchable when it is word aligned and a whole word fits in the ROM.
    // Operands are widened to 64 bits so a PC near the top of the address space
    // cannot alias back into the ROM range.
    function automatic logic pc_is_legal(input logic [63:0] pc, input logic [63:0] rom_bytes);
        return (pc[1:0] == 2'b00) && ((pc + 64'(INSTR_BYTES)) <= rom_bytes);
    endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready holding register between fetch and decode.
module fetch_out_reg
    import fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     flush,
    input  logic                     out_ready,
    input  logic [31:0]              instr_in,
    input  logic [ADDRESS_WIDTH-1:0] pc_in,
    output logic                     out_valid,
    output logic [31:0]              instr_out,
    output logic [ADDRESS_WIDTH-1:0] instr_pc
);

    logic                     valid_q, valid_d;
    logic [31:0]              instr_q, instr_d;
    logic [ADDRESS_WIDTH-1:0] ipc_q, ipc_d;

    // Flush wins, then a new load; otherwise a consumed word simply drains.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = instr_in;
            ipc_d   = pc_in;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    assign out_valid = valid_q;
    assign instr_out = instr_q;
    assign instr_pc  = ipc_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, sequences the ROM, handles
// redirects and flags illegal fetch addresses.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       ROM_BYTES     = 28,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [31:0]              rom_instr,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [31:0]              instr_out,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    output logic                     fault,
    output logic [31:0]              fetch_count
);

    fetch_state_t             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic                     fault_q, fault_d;
    logic [31:0]              count_q, count_d;
    logic                     load, flush;
    logic                     xfer, slot_free, pc_legal, tgt_legal;

    assign xfer      = out_valid && out_ready;
    assign slot_free = !out_valid || out_ready;
    assign pc_legal  = pc_is_legal(64'(pc_q), 64'(ROM_BYTES));
    assign tgt_legal = pc_is_legal(64'(redirect_target), 64'(ROM_BYTES));

    // Next-state: redirect overrides the normal fetch sequence.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        count_d = count_q;
        load    = 1'b0;
        flush   = 1'b0;
        if (xfer) begin
            count_d = count_q + 32'd1;
        end
        if (redirect_valid) begin
            flush   = 1'b1;
            pc_d    = redirect_target;
            fault_d = !tgt_legal;
            state_d = tgt_legal ? FETCH : FAULT;
        end else begin
            case (state_q)
                BOOT: state_d = FETCH;
                FETCH: begin
                    if (slot_free) begin
                        if (pc_legal) begin
                            load = 1'b1;
                            pc_d = pc_q + ADDRESS_WIDTH'(INSTR_BYTES);
                        end else begin
                            state_d = FAULT;
                            fault_d = 1'b1;
                        end
                    end
                end
                FAULT: state_d = FAULT;
                default: state_d = BOOT;
            endcase
        end
    end

    // PC, state, sticky fault and transfer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    fetch_out_reg #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .flush     (flush),
        .out_ready (out_ready),
        .instr_in  (rom_instr),
        .pc_in     (pc_q),
        .out_valid (out_valid),
        .instr_out (instr_out),
        .instr_pc  (instr_pc)
    );

    assign rom_addr    = pc_q;
    assign fault       = fault_q;
    assign fetch_count = count_q;

endmodule
